// File: rtl/quan_pkg.sv
// Shared widths and helpers for the per-channel requantisation pipeline.
package quan_pkg;

   localparam int unsigned DIN_W_DEF   = 18;
   localparam int unsigned MID_W_DEF   = 16;
   localparam int unsigned M0_W_DEF    = 16;
   localparam int unsigned SHIFT_W_DEF = 4;
   localparam int unsigned DOUT_W_DEF  = 8;
   localparam int unsigned CH_NUM_DEF  = 8;

   function automatic int unsigned ch_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Clamp a signed value into the range of a signed field of the given width.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/quan_param_table.sv
// Per-channel requantisation parameters: one write port, one combinational read port.
module quan_param_table #(
   parameter int unsigned CH_NUM  = 8,
   parameter int unsigned CH_W    = 3,
   parameter int unsigned M0_W    = 16,
   parameter int unsigned SHIFT_W = 4,
   parameter int unsigned ZP_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we_i,
   input  logic [CH_W-1:0]    wr_ch_i,
   input  logic [M0_W-1:0]    m0_i,
   input  logic [SHIFT_W-1:0] shift_i,
   input  logic [ZP_W-1:0]    zp_i,
   input  logic [CH_W-1:0]    rd_ch_i,
   output logic [M0_W-1:0]    rd_m0_c,
   output logic [SHIFT_W-1:0] rd_shift_c,
   output logic [ZP_W-1:0]    rd_zp_c
);

   logic [M0_W-1:0]    m0_q    [CH_NUM];
   logic [SHIFT_W-1:0] shift_q [CH_NUM];
   logic [ZP_W-1:0]    zp_q    [CH_NUM];

   // Out-of-range channel indices are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            m0_q[i]    <= '0;
            shift_q[i] <= '0;
            zp_q[i]    <= '0;
         end
      end else if (we_i && (32'(wr_ch_i) < CH_NUM)) begin
         m0_q[wr_ch_i]    <= m0_i;
         shift_q[wr_ch_i] <= shift_i;
         zp_q[wr_ch_i]    <= zp_i;
      end
   end

   assign rd_m0_c    = m0_q[rd_ch_i];
   assign rd_shift_c = shift_q[rd_ch_i];
   assign rd_zp_c    = zp_q[rd_ch_i];

endmodule

// File: rtl/requant_pipe.sv
// Four-stage per-channel requantiser: saturate, multiply, shift, offset/clamp.
// Define QUAN_ROUND_EN for round-half-up in the shift stage; default is floor.
module requant_pipe
   import quan_pkg::*;
#(
   parameter int unsigned DIN_W   = DIN_W_DEF,
   parameter int unsigned MID_W   = MID_W_DEF,
   parameter int unsigned M0_W    = M0_W_DEF,
   parameter int unsigned SHIFT_W = SHIFT_W_DEF,
   parameter int unsigned DOUT_W  = DOUT_W_DEF,
   parameter int unsigned CH_NUM  = CH_NUM_DEF,
   parameter int unsigned CH_W    = ch_w(CH_NUM)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [M0_W-1:0]    cfg_m0,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic [DOUT_W-1:0]  cfg_zp,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sof,
   input  logic [DIN_W-1:0]   din,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH_W-1:0]    out_ch,
   output logic [DOUT_W-1:0]  dout
);

   localparam int unsigned P_W = MID_W + M0_W;
   localparam int unsigned R_W = P_W + 1;
   localparam int unsigned N_W = 8;
   localparam logic signed [63:0] Y_MAX = (64'sd1 <<< DOUT_W) - 64'sd1;

   logic                      en_c;
   logic                      acc_c;
   logic [CH_W-1:0]           ch_c;
   logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
   logic [M0_W-1:0]           tbl_m0_c;
   logic [SHIFT_W-1:0]        tbl_shift_c;
   logic [DOUT_W-1:0]         tbl_zp_c;

   logic                      v1_q, v2_q, v3_q, out_valid_q;
   logic [CH_W-1:0]           ch1_q, ch2_q, ch3_q, out_ch_q;
   logic signed [MID_W-1:0]   s1_q, s1_d;
   logic signed [M0_W-1:0]    m0_1_q;
   logic [SHIFT_W-1:0]        sh1_q, sh2_q;
   logic [DOUT_W-1:0]         zp1_q, zp2_q, zp3_q;
   logic signed [P_W-1:0]     p2_q, p2_d;
   logic signed [R_W-1:0]     r3_q, r3_d;
   logic [DOUT_W-1:0]         dout_q, dout_d;
   logic [N_W-1:0]            n_c;
   logic signed [63:0]        q_c, y_c;
`ifdef QUAN_ROUND_EN
   logic signed [R_W-1:0]     rnd_c;
`endif

   quan_param_table #(
      .CH_NUM (CH_NUM),
      .CH_W   (CH_W),
      .M0_W   (M0_W),
      .SHIFT_W(SHIFT_W),
      .ZP_W   (DOUT_W)
   ) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (cfg_we),
      .wr_ch_i   (cfg_ch),
      .m0_i      (cfg_m0),
      .shift_i   (cfg_shift),
      .zp_i      (cfg_zp),
      .rd_ch_i   (ch_c),
      .rd_m0_c   (tbl_m0_c),
      .rd_shift_c(tbl_shift_c),
      .rd_zp_c   (tbl_zp_c)
   );

   // Global stall: every stage moves together only when the output slot frees up.
   always_comb begin
      en_c     = !out_valid_q || out_ready;
      acc_c    = in_valid && en_c;
      ch_c     = in_sof ? '0 : ch_cnt_q;
      ch_cnt_d = ch_cnt_q;
      if (acc_c) begin
         ch_cnt_d = (32'(ch_c) == CH_NUM - 1) ? '0 : ch_c + CH_W'(1);
      end
   end

   always_comb begin
      s1_d = MID_W'(sat_signed(64'($signed(din)), MID_W));
      p2_d = P_W'(s1_q) * P_W'(m0_1_q);
      n_c  = N_W'(M0_W - 1) + N_W'(sh2_q);
`ifdef QUAN_ROUND_EN
      rnd_c = R_W'(1) <<< (n_c - N_W'(1));
      r3_d  = (R_W'(p2_q) + rnd_c) >>> n_c;
`else
      r3_d  = R_W'(p2_q) >>> n_c;
`endif
      q_c  = sat_signed(64'(r3_q), DOUT_W);
      y_c  = q_c + $signed(64'(zp3_q));
      if (y_c < 64'sd0) begin
         dout_d = '0;
      end else if (y_c > Y_MAX) begin
         dout_d = '1;
      end else begin
         dout_d = DOUT_W'(y_c);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_cnt_q    <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         ch1_q       <= '0;
         ch2_q       <= '0;
         ch3_q       <= '0;
         out_ch_q    <= '0;
         s1_q        <= '0;
         m0_1_q      <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         zp1_q       <= '0;
         zp2_q       <= '0;
         zp3_q       <= '0;
         p2_q        <= '0;
         r3_q        <= '0;
         dout_q      <= '0;
      end else begin
         ch_cnt_q <= ch_cnt_d;
         if (en_c) begin
            // Parameters are captured with the beat so later table writes cannot reach it.
            v1_q        <= in_valid;
            ch1_q       <= ch_c;
            s1_q        <= s1_d;
            m0_1_q      <= tbl_m0_c;
            sh1_q       <= tbl_shift_c;
            zp1_q       <= tbl_zp_c;
            v2_q        <= v1_q;
            ch2_q       <= ch1_q;
            p2_q        <= p2_d;
            sh2_q       <= sh1_q;
            zp2_q       <= zp1_q;
            v3_q        <= v2_q;
            ch3_q       <= ch2_q;
            r3_q        <= r3_d;
            zp3_q       <= zp2_q;
            out_valid_q <= v3_q;
            out_ch_q    <= ch3_q;
            dout_q      <= dout_d;
         end
      end
   end

   assign in_ready  = en_c;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign dout      = dout_q;

endmodule

// File: tb/tb_requant_pipe.sv
// Self-checking bench for requant_pipe against a plain-arithmetic reference model.
module tb_requant_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_ch;
   logic [15:0] cfg_m0;
   logic [3:0]  cfg_shift;
   logic [7:0]  cfg_zp;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic [17:0] din;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ch;
   logic [7:0]  dout;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [2:0] ch;
      logic [7:0] d;
   } exp_t;
   exp_t sb[$];

   logic [15:0] m0_t [8];
   logic [3:0]  sh_t [8];
   logic [7:0]  zp_t [8];
   int          mch;

   always #5 clk = ~clk;

   requant_pipe dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_m0   (cfg_m0),
      .cfg_shift(cfg_shift),
      .cfg_zp   (cfg_zp),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sof   (in_sof),
      .din      (din),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ch   (out_ch),
      .dout     (dout)
   );

   function automatic logic [7:0] model(longint x, longint m0, int sh, longint zp);
      longint s, p, r, q, y;
      int n;
      s = (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
      p = s * m0;
      n = 15 + sh;
`ifdef QUAN_ROUND_EN
      r = (p + (longint'(1) <<< (n - 1))) >>> n;
`else
      r = p >>> n;
`endif
      q = (r > 127) ? 127 : ((r < -128) ? -128 : r);
      y = q + zp;
      y = (y < 0) ? 0 : ((y > 255) ? 255 : y);
      return 8'(y);
   endfunction

   // One clock: sample at negedge, log accepted beats and table writes, return after posedge.
   task automatic step(output logic f, output logic ov, output logic [7:0] d,
                       output logic [2:0] c, output logic ir);
      exp_t e;
      int   ch;
      @(negedge clk);
      ov = out_valid;
      f  = out_valid && out_ready;
      d  = dout;
      c  = out_ch;
      ir = in_ready;
      if (in_valid && in_ready) begin
         ch   = in_sof ? 0 : mch;
         e.ch = 3'(ch);
         e.d  = model(longint'($signed(din)), longint'($signed(m0_t[ch])),
                      int'(sh_t[ch]), longint'(zp_t[ch]));
         sb.push_back(e);
         mch = (ch == 7) ? 0 : ch + 1;
      end
      if (cfg_we) begin
         m0_t[cfg_ch] = cfg_m0;
         sh_t[cfg_ch] = cfg_shift;
         zp_t[cfg_ch] = cfg_zp;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int ch, input int m0, input int sh, input int zp);
      logic f, ov, ir;
      logic [7:0] d;
      logic [2:0] c;
      cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_m0 = 16'(m0); cfg_shift = 4'(sh); cfg_zp = 8'(zp);
      step(f, ov, d, c, ir);
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_m0 = '0; cfg_shift = '0; cfg_zp = '0;
      in_valid = 1'b0; in_sof = 1'b0; din = '0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin m0_t[i] = '0; sh_t[i] = '0; zp_t[i] = '0; end
      mch = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors += 4;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      if (dout !== 8'd0)      begin miscompares++; $display("FAIL reset dout got %0d want 0", dout); end
      if (out_ch !== 3'd0)    begin miscompares++; $display("FAIL reset out_ch got %0d want 0", out_ch); end
      if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic f, ov, ir;
      logic [7:0] d, d_s;
      logic [2:0] c, c_s;
      int lat;
      cfg_write(0, 16384, 2, 3);
      in_valid = 1'b1; in_sof = 1'b1; din = 18'(1000);
      step(f, ov, d, c, ir);
      in_valid = 1'b0; in_sof = 1'b0;
      lat = 0; d_s = 'x; c_s = 'x;
      for (int k = 1; k <= 10; k++) begin
         step(f, ov, d, c, ir);
         if (ov) begin lat = k; d_s = d; c_s = c; break; end
      end
      vectors += 3;
      if (lat != 4)      begin miscompares++; $display("FAIL basic latency got %0d want 4", lat); end
      if (d_s !== 8'd128) begin miscompares++; $display("FAIL basic dout got %0d want 128", d_s); end
      if (c_s !== 3'd0)   begin miscompares++; $display("FAIL basic out_ch got %0d want 0", c_s); end
      sb.delete();
   endtask

   task automatic test_rounding();
      logic f, ov, ir, got;
      logic [7:0] d;
      logic [2:0] c;
      int vd[4], vz[4], ve[4];
      vd = '{3, -3, 3, -3};
      vz = '{0, 10, 0, 0};
`ifdef QUAN_ROUND_EN
      ve = '{2, 9, 2, 0};
`else
      ve = '{1, 8, 1, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         cfg_write(0, 16384, 0, vz[i]);
         in_valid = 1'b1; in_sof = 1'b1; din = 18'(vd[i]);
         step(f, ov, d, c, ir);
         in_valid = 1'b0; in_sof = 1'b0; got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            step(f, ov, d, c, ir);
            if (f) begin
               got = 1'b1; vectors++;
               if (d !== 8'(ve[i])) begin
                  miscompares++;
                  $display("FAIL round[%0d] din=%0d zp=%0d got %0d want %0d", i, vd[i], vz[i], d, ve[i]);
               end
            end
         end
         if (!got) begin vectors++; miscompares++; $display("FAIL round[%0d] timeout", i); end
      end
      sb.delete();
   endtask

   task automatic test_saturation();
      logic f, ov, ir, got;
      logic [7:0] d;
      logic [2:0] c;
      int vd[3], vz[3], ve[3];
      vd = '{131071, -131072, 70000};
      vz = '{10, 0, 255};
      ve = '{137, 0, 255};
      for (int i = 0; i < 3; i++) begin
         cfg_write(0, 32767, 0, vz[i]);
         in_valid = 1'b1; in_sof = 1'b1; din = 18'(vd[i]);
         step(f, ov, d, c, ir);
         in_valid = 1'b0; in_sof = 1'b0; got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            step(f, ov, d, c, ir);
            if (f) begin
               got = 1'b1; vectors++;
               if (d !== 8'(ve[i])) begin
                  miscompares++;
                  $display("FAIL sat[%0d] din=%0d got %0d want %0d", i, vd[i], d, ve[i]);
               end
            end
         end
         if (!got) begin vectors++; miscompares++; $display("FAIL sat[%0d] timeout", i); end
      end
      sb.delete();
   endtask

   task automatic test_channel_seq();
      logic f, ov, ir;
      logic [7:0] d;
      logic [2:0] c;
      logic [7:0] od[$];
      logic [2:0] oc[$];
      for (int i = 0; i < 8; i++) cfg_write(i, 0, $urandom_range(0, 15), 16 + 9 * i);
      for (int b = 0; b < 10; b++) begin
         in_valid = 1'b1; in_sof = (b == 0 || b == 5); din = 18'($urandom);
         step(f, ov, d, c, ir);
         if (f) begin od.push_back(d); oc.push_back(c); end
      end
      in_valid = 1'b0; in_sof = 1'b0;
      for (int k = 0; k < 20 && od.size() < 10; k++) begin
         step(f, ov, d, c, ir);
         if (f) begin od.push_back(d); oc.push_back(c); end
      end
      vectors++;
      if (od.size() != 10) begin miscompares++; $display("FAIL chseq count got %0d want 10", od.size()); end
      for (int i = 0; i < od.size() && i < 10; i++) begin
         vectors += 2;
         if (oc[i] !== 3'(i % 5)) begin
            miscompares++; $display("FAIL chseq[%0d] out_ch got %0d want %0d", i, oc[i], i % 5);
         end
         if (od[i] !== 8'(16 + 9 * (i % 5))) begin
            miscompares++; $display("FAIL chseq[%0d] dout got %0d want %0d", i, od[i], 16 + 9 * (i % 5));
         end
      end
      sb.delete();
   endtask

   task automatic test_backpressure();
      logic f, ov, ir;
      logic [7:0] d, d_prev;
      logic [2:0] c, c_prev;
      exp_t e;
      int n_in, n_out;
      for (int i = 0; i < 8; i++)
         cfg_write(i, 8192 + $urandom_range(0, 16383), $urandom_range(0, 3), $urandom_range(0, 200));
      n_in = 0; n_out = 0; d_prev = '0; c_prev = '0;
      for (int cyc = 0; cyc < 40 && (n_in < 12 || n_out < 12); cyc++) begin
         in_valid  = (n_in < 12);
         in_sof    = (n_in == 0);
         din       = 18'($signed(14'($urandom)));
         out_ready = !(cyc >= 6 && cyc < 9);
         cfg_we    = (cyc == 7);
         cfg_ch    = 3'd2; cfg_m0 = 16'($urandom); cfg_shift = 4'($urandom); cfg_zp = 8'($urandom);
         step(f, ov, d, c, ir);
         cfg_we = 1'b0;
         if (in_valid && ir) n_in++;
         if (cyc >= 6 && cyc < 9) begin
            vectors += 2;
            if (ir !== 1'b0) begin miscompares++; $display("FAIL bp in_ready cyc%0d got %b want 0", cyc, ir); end
            if (ov !== 1'b1) begin miscompares++; $display("FAIL bp out_valid cyc%0d got %b want 1", cyc, ov); end
            if (cyc > 6) begin
               vectors++;
               if (d !== d_prev || c !== c_prev) begin
                  miscompares++;
                  $display("FAIL bp hold cyc%0d got ch=%0d dout=%0d want ch=%0d dout=%0d", cyc, c, d, c_prev, d_prev);
               end
            end
         end
         if (f) begin
            n_out++; vectors++;
            if (sb.size() == 0) begin
               miscompares++; $display("FAIL bp unexpected beat ch=%0d dout=%0d", c, d);
            end else begin
               e = sb.pop_front();
               if (d !== e.d || c !== e.ch) begin
                  miscompares++;
                  $display("FAIL bp beat got ch=%0d dout=%0d want ch=%0d dout=%0d", c, d, e.ch, e.d);
               end
            end
         end
         d_prev = d; c_prev = c;
      end
      in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      vectors += 2;
      if (n_out != 12)    begin miscompares++; $display("FAIL bp beats out got %0d want 12", n_out); end
      if (sb.size() != 0) begin miscompares++; $display("FAIL bp leftover got %0d want 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_random();
      logic f, ov, ir;
      logic [7:0] d;
      logic [2:0] c;
      exp_t e;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = (cyc < 360) && ($urandom_range(0, 9) < 7);
         in_sof    = ($urandom_range(0, 9) == 0);
         din       = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($signed(13'($urandom)));
         out_ready = (cyc >= 360) || ($urandom_range(0, 9) < 7);
         cfg_we    = ($urandom_range(0, 9) == 0);
         cfg_ch    = 3'($urandom); cfg_m0 = 16'($urandom);
         cfg_shift = 4'($urandom_range(0, 4)); cfg_zp = 8'($urandom);
         step(f, ov, d, c, ir);
         vectors++;
         if (ir !== (!ov || out_ready)) begin
            miscompares++; $display("FAIL rnd in_ready cyc%0d got %b want %b", cyc, ir, !ov || out_ready);
         end
         if (f) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++; $display("FAIL rnd unexpected beat ch=%0d dout=%0d", c, d);
            end else begin
               e = sb.pop_front();
               if (d !== e.d || c !== e.ch) begin
                  miscompares++;
                  $display("FAIL rnd beat cyc%0d got ch=%0d dout=%0d want ch=%0d dout=%0d", cyc, c, d, e.ch, e.d);
               end
            end
         end
      end
      cfg_we = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL rnd leftover got %0d want 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_reset_midstream();
      logic f, ov, ir, got;
      logic [7:0] d;
      logic [2:0] c;
      exp_t e;
      for (int i = 0; i < 8; i++) cfg_write(i, 16384, 0, 50);
      for (int b = 0; b < 5; b++) begin
         in_valid = 1'b1; in_sof = (b == 0); din = 18'($urandom_range(10, 200));
         step(f, ov, d, c, ir);
         if (f) begin
            vectors++;
            e = sb.pop_front();
            if (d !== e.d || c !== e.ch) begin
               miscompares++;
               $display("FAIL rstmid beat got ch=%0d dout=%0d want ch=%0d dout=%0d", c, d, e.ch, e.d);
            end
         end
      end
      in_valid = 1'b0; in_sof = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors += 3;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid out_valid got %b want 0", out_valid); end
      if (dout !== 8'd0)      begin miscompares++; $display("FAIL rstmid dout got %0d want 0", dout); end
      if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
      sb.delete();
      for (int i = 0; i < 8; i++) begin m0_t[i] = '0; sh_t[i] = '0; zp_t[i] = '0; end
      mch = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_sof = 1'b0; din = 18'(1234);
      step(f, ov, d, c, ir);
      in_valid = 1'b0; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         step(f, ov, d, c, ir);
         if (f) begin
            got = 1'b1; vectors += 2;
            if (c !== 3'd0) begin miscompares++; $display("FAIL rstmid post out_ch got %0d want 0", c); end
            if (d !== 8'd0) begin miscompares++; $display("FAIL rstmid post dout got %0d want 0", d); end
         end
      end
      if (!got) begin vectors++; miscompares++; $display("FAIL rstmid post timeout"); end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_channel_seq();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
